// File: rtl/icache_event_counters_if.sv
`default_nettype none
// ============================================================================
//  Module   : icache_event_counters_if
//  Purpose  : Read request/response channel of the icache event counter bank.
//             The bank is the slave, the CSR/peripheral reader the master.
//  Revision : 1.0 - initial release
// ============================================================================
interface icache_event_counters_if #(
  parameter int IDX_WIDTH = 4,
  parameter int CNT_WIDTH = 32
);
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [IDX_WIDTH-1:0] req_idx_i;
  logic                 req_clear_i;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [CNT_WIDTH-1:0] rsp_data_o;
  logic                 rsp_overflow_o;
  logic                 rsp_error_o;

  // Reader side
  modport master (
    output req_valid_i, req_idx_i, req_clear_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_overflow_o, rsp_error_o
  );

  // Counter bank side
  modport slave (
    input  req_valid_i, req_idx_i, req_clear_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_overflow_o, rsp_error_o
  );
endinterface
`default_nettype wire

// File: rtl/icache_event_counters.sv
`default_nettype none
// ============================================================================
//  Module   : icache_event_counters
//  Purpose  : Performance counter bank for the instruction cache. One counter
//             per L0 event per fetch port plus one per L1 event, with wrap or
//             saturate overflow, sticky overflow flags, global enable/clear
//             and a valid/ready read port with optional read-and-clear.
//  Revision : 1.0 - initial release
// ============================================================================
// Event vectors follow the packed struct layouts (first member is the MSB):
//   icache_l0_events_t = {l0_miss, l0_hit, l0_prefetch, l0_double_hit, l0_stall}
//   icache_l1_events_t = {l1_miss, l1_hit, l1_stall, l1_handler_stall}
module icache_event_counters #(
  parameter int NR_FETCH_PORTS = 1,
  parameter int CNT_WIDTH      = 32,
  parameter int SATURATE       = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [NR_FETCH_PORTS-1:0][4:0]  l0_events_i,
  input  logic [3:0]                      l1_events_i,
  input  logic                            enable_i,
  input  logic                            clear_i,
  icache_event_counters_if.slave          bus
);

  localparam int NUM_CNT   = 5 * NR_FETCH_PORTS + 4;
  localparam int IDX_WIDTH = $clog2(NUM_CNT);
  localparam int L1_BASE   = 5 * NR_FETCH_PORTS;

  // Bit positions inside the packed event structs
  localparam int c_L0_MISS          = 4;
  localparam int c_L0_HIT           = 3;
  localparam int c_L0_PREFETCH      = 2;
  localparam int c_L0_DOUBLE_HIT    = 1;
  localparam int c_L0_STALL         = 0;
  localparam int c_L1_MISS          = 3;
  localparam int c_L1_HIT           = 2;
  localparam int c_L1_STALL         = 1;
  localparam int c_L1_HANDLER_STALL = 0;

  logic [NUM_CNT-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [NUM_CNT-1:0]                ovf_q, ovf_d;

  logic                 rsp_valid_q;
  logic [CNT_WIDTH-1:0] rsp_data_q;
  logic                 rsp_overflow_q;
  logic                 rsp_error_q;

  logic [NUM_CNT-1:0]   w_events;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_idx_ok;
  logic [CNT_WIDTH-1:0] w_rd_data;
  logic                 w_rd_ovf;

  // Flatten the per-port L0 structs into counter order (base 5*p)
  for (genvar p = 0; p < NR_FETCH_PORTS; p++) begin : g_l0_map
    assign w_events[5*p + 0] = l0_events_i[p][c_L0_MISS];
    assign w_events[5*p + 1] = l0_events_i[p][c_L0_HIT];
    assign w_events[5*p + 2] = l0_events_i[p][c_L0_PREFETCH];
    assign w_events[5*p + 3] = l0_events_i[p][c_L0_DOUBLE_HIT];
    assign w_events[5*p + 4] = l0_events_i[p][c_L0_STALL];
  end

  assign w_events[L1_BASE + 0] = l1_events_i[c_L1_MISS];
  assign w_events[L1_BASE + 1] = l1_events_i[c_L1_HIT];
  assign w_events[L1_BASE + 2] = l1_events_i[c_L1_STALL];
  assign w_events[L1_BASE + 3] = l1_events_i[c_L1_HANDLER_STALL];

  // A new request can be taken when the response slot is empty or draining
  assign w_req_ready = !rsp_valid_q || bus.rsp_ready_i;
  assign w_accept    = bus.req_valid_i && w_req_ready;
  assign w_idx_ok    = (32'(bus.req_idx_i) < NUM_CNT);
  assign w_rd_data   = w_idx_ok ? cnt_q[bus.req_idx_i] : '0;
  assign w_rd_ovf    = w_idx_ok ? ovf_q[bus.req_idx_i] : 1'b0;

  // Next-state of every counter: global clear, then read-and-clear, then event
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (clear_i) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else begin
        // Zeroing first lets a same-cycle event land on the cleared counter
        if (w_accept && bus.req_clear_i && w_idx_ok && (32'(bus.req_idx_i) == i)) begin
          cnt_d[i] = '0;
          ovf_d[i] = 1'b0;
        end
        if (enable_i && w_events[i]) begin
          if (cnt_d[i] == '1) begin
            ovf_d[i] = 1'b1;
            if (SATURATE == 0) begin
              cnt_d[i] = '0;
            end
          end else begin
            cnt_d[i] = cnt_d[i] + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

  // Counter and overflow flag storage
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Response slot: captured on acceptance, released once consumed
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_error_q    <= 1'b0;
    end else if (w_accept) begin
      rsp_valid_q    <= 1'b1;
      rsp_data_q     <= w_rd_data;
      rsp_overflow_q <= w_rd_ovf;
      rsp_error_q    <= !w_idx_ok;
    end else if (bus.rsp_ready_i) begin
      rsp_valid_q    <= 1'b0;
    end
  end

  assign bus.req_ready_o    = w_req_ready;
  assign bus.rsp_valid_o    = rsp_valid_q;
  assign bus.rsp_data_o     = rsp_data_q;
  assign bus.rsp_overflow_o = rsp_overflow_q;
  assign bus.rsp_error_o    = rsp_error_q;

endmodule
`default_nettype wire
